bus_grant_ctrl: RTL and testbench

- Sits directly downstream of the 8-bit priority generator on the shared bus.
- Samples master requests, pulses the generator's enable, and consumes its registered one-hot winner.
- Holds that grant until the owning master drops its request or a hold-timeout fires.
- Drives the bus-ownership outputs consumed by the bus mux and by the masters.

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/onehot_to_bin.sv | 20 ++
 rtl/bus_grant_ctrl.sv | 122 ++++++++++++
 tb/tb_bus_grant_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and sizing for the shared-bus arbitration path.
// Used by the grant controller and the one-hot encoder.
package bus_arb_pkg;

    localparam int NUM_MASTERS = 8;
    localparam int ID_W        = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        GRANT  = 2'd2,
        TURN   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary index encoder (8 -> 3).
// Shared by the grant path and bus decode logic.
module onehot_to_bin
    import bus_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] onehot,
    output logic [ID_W-1:0]        bin
);

    // OR-reduction form: exact for one-hot inputs, no priority chain.
    always_comb begin
        bin = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (onehot[i]) begin
                bin = bin | ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_grant_ctrl.sv
// Bus grant controller: arbitrates through the external priority generator,
// holds the grant until request drop or hold timeout, then inserts a dead cycle.
module bus_grant_ctrl
    import bus_arb_pkg::*;
#(
    parameter int MAX_HOLD = 64,
    parameter int CNT_W    = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] pri_req,
    output logic                   pri_en,
    input  logic [NUM_MASTERS-1:0] pri_onehot,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [ID_W-1:0]        grant_id,
    output logic                   bus_busy,
    output logic                   timeout
);

    arb_state_t             state, state_n;
    logic [NUM_MASTERS-1:0] grant_n;
    logic [ID_W-1:0]        grant_id_n;
    logic                   bus_busy_n;
    logic                   timeout_n;
    logic [CNT_W-1:0]       hold_cnt, hold_cnt_n;
    logic [NUM_MASTERS-1:0] penalty_mask, penalty_mask_n;
    logic [ID_W-1:0]        winner_id;
    logic                   winner_valid;

    onehot_to_bin u_enc (
        .onehot (pri_onehot),
        .bin    (winner_id)
    );

    assign pri_req      = req & ~penalty_mask;
    // Winner must still be requesting when the registered result arrives.
    assign winner_valid = (pri_onehot != '0) && ((pri_onehot & req) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            grant_id     <= '0;
            bus_busy     <= 1'b0;
            timeout      <= 1'b0;
            hold_cnt     <= '0;
            penalty_mask <= '0;
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            grant_id     <= grant_id_n;
            bus_busy     <= bus_busy_n;
            timeout      <= timeout_n;
            hold_cnt     <= hold_cnt_n;
            penalty_mask <= penalty_mask_n;
        end
    end

    always_comb begin
        state_n        = state;
        grant_n        = grant;
        grant_id_n     = grant_id;
        bus_busy_n     = bus_busy;
        timeout_n      = 1'b0;
        hold_cnt_n     = hold_cnt;
        penalty_mask_n = penalty_mask;
        pri_en         = 1'b0;

        case (state)
            IDLE: begin
                if (pri_req != '0) begin
                    // Kept low under reset so the generator never latches then.
                    pri_en  = ~rst;
                    state_n = SAMPLE;
                end else if (penalty_mask != '0) begin
                    penalty_mask_n = '0;
                end
            end

            SAMPLE: begin
                if (winner_valid) begin
                    grant_n        = pri_onehot;
                    grant_id_n     = winner_id;
                    bus_busy_n     = 1'b1;
                    hold_cnt_n     = CNT_W'(1);
                    penalty_mask_n = '0;
                    state_n        = GRANT;
                end else begin
                    state_n = IDLE;
                end
            end

            GRANT: begin
                if (!req[grant_id]) begin
                    grant_n    = '0;
                    bus_busy_n = 1'b0;
                    hold_cnt_n = '0;
                    state_n    = TURN;
                end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
                    grant_n        = '0;
                    bus_busy_n     = 1'b0;
                    timeout_n      = 1'b1;
                    penalty_mask_n = grant;
                    hold_cnt_n     = '0;
                    state_n        = TURN;
                end else begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end
            end

            TURN: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Directed bench for bus_grant_ctrl with a behavioural priority generator
// (lowest index wins, registered on pri_en); MAX_HOLD reduced to 4.
module tb_bus_grant_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] pri_req;
    logic       pri_en;
    logic [7:0] pri_onehot;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       bus_busy;
    logic       timeout;

    int checks;
    int failures;

    bus_grant_ctrl #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .pri_req    (pri_req),
        .pri_en     (pri_en),
        .pri_onehot (pri_onehot),
        .grant      (grant),
        .grant_id   (grant_id),
        .bus_busy   (bus_busy),
        .timeout    (timeout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // priority generator model: bit 0 highest priority
    logic [7:0] gen_lowest;
    assign gen_lowest = pri_req & (~pri_req + 8'd1);
    always @(posedge clk) begin
        if (rst) pri_onehot <= 8'h00;
        else if (pri_en) pri_onehot <= gen_lowest;
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 8'h00;
        cyc();
        cyc();
        req = 8'h10;
        #1;
        checks++; if (pri_en !== 1'b0) begin failures++; $display("FAIL reset_pri_en: got %b want 0", pri_en); end
        checks++; if (grant !== 8'h00) begin failures++; $display("FAIL reset_grant: got %h want 00", grant); end
        checks++; if (grant_id !== 3'd0) begin failures++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus_busy); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        rst = 1'b0;
        req = 8'h00;
    endtask

    task automatic test_single();
        cyc(); req = 8'h10; #1;
        checks++; if (pri_en !== 1'b1) begin failures++; $display("FAIL single_pri_en: got %b want 1", pri_en); end
        checks++; if (pri_req !== 8'h10) begin failures++; $display("FAIL single_pri_req: got %h want 10", pri_req); end
        cyc(); #1;
        checks++; if (grant !== 8'h00) begin failures++; $display("FAIL single_sample_grant: got %h want 00", grant); end
        checks++; if (pri_en !== 1'b0) begin failures++; $display("FAIL single_sample_pri_en: got %b want 0", pri_en); end
        cyc(); #1;
        checks++; if (grant !== 8'h10) begin failures++; $display("FAIL single_grant: got %h want 10", grant); end
        checks++; if (grant_id !== 3'd4) begin failures++; $display("FAIL single_grant_id: got %0d want 4", grant_id); end
        checks++; if (bus_busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", bus_busy); end
        req = 8'h00;
        cyc(); #1;
        checks++; if (grant !== 8'h00) begin failures++; $display("FAIL single_release: got %h want 00", grant); end
        checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL single_release_busy: got %b want 0", bus_busy); end
        checks++; if (pri_en !== 1'b0) begin failures++; $display("FAIL single_turn_pri_en: got %b want 0", pri_en); end
        cyc(); #1;
        checks++; if (grant !== 8'h00) begin failures++; $display("FAIL single_idle_grant: got %h want 00", grant); end
    endtask

    task automatic test_priority();
        cyc(); req = 8'h82; #1;
        checks++; if (pri_en !== 1'b1) begin failures++; $display("FAIL prio_pri_en: got %b want 1", pri_en); end
        cyc();
        cyc(); #1;
        checks++; if (grant !== 8'h02) begin failures++; $display("FAIL prio_grant_m1: got %h want 02", grant); end
        checks++; if (grant_id !== 3'd1) begin failures++; $display("FAIL prio_id_m1: got %0d want 1", grant_id); end
        req = 8'h80;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            checks++; if (grant !== 8'h00) begin failures++; $display("FAIL prio_gap_%0d: got %h want 00", i, grant); end
        end
        cyc(); #1;
        checks++; if (grant !== 8'h80) begin failures++; $display("FAIL prio_grant_m7: got %h want 80", grant); end
        checks++; if (grant_id !== 3'd7) begin failures++; $display("FAIL prio_id_m7: got %0d want 7", grant_id); end
        req = 8'h00;
        cyc();
        cyc();
    endtask

    task automatic test_no_preempt();
        cyc(); req = 8'h20;
        cyc();
        cyc(); #1;
        checks++; if (grant !== 8'h20) begin failures++; $display("FAIL nopre_grant: got %h want 20", grant); end
        checks++; if (grant_id !== 3'd5) begin failures++; $display("FAIL nopre_id: got %0d want 5", grant_id); end
        req = 8'h21;
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            checks++; if (grant !== 8'h20) begin failures++; $display("FAIL nopre_hold_%0d: got %h want 20", i, grant); end
        end
        req = 8'h01;
        cyc(); #1;
        checks++; if (grant !== 8'h00) begin failures++; $display("FAIL nopre_release: got %h want 00", grant); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL nopre_no_timeout: got %b want 0", timeout); end
        cyc();
        cyc();
        cyc(); #1;
        checks++; if (grant !== 8'h01) begin failures++; $display("FAIL nopre_next_owner: got %h want 01", grant); end
        req = 8'h00;
        cyc();
        cyc();
    endtask

    task automatic test_timeout();
        cyc(); req = 8'h03;
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            checks++; if (grant !== 8'h01) begin failures++; $display("FAIL to_hold_m0_%0d: got %h want 01", i, grant); end
            checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_early_pulse_%0d: got %b want 0", i, timeout); end
        end
        cyc(); #1;
        checks++; if (grant !== 8'h00) begin failures++; $display("FAIL to_release_m0: got %h want 00", grant); end
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_pulse_m0: got %b want 1", timeout); end
        checks++; if (pri_en !== 1'b0) begin failures++; $display("FAIL to_pri_en_with_pulse: got %b want 0", pri_en); end
        cyc(); #1;
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_pulse_width: got %b want 0", timeout); end
        checks++; if (pri_req !== 8'h02) begin failures++; $display("FAIL to_penalty_m0: got %h want 02", pri_req); end
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            checks++; if (grant !== 8'h02) begin failures++; $display("FAIL to_hold_m1_%0d: got %h want 02", i, grant); end
        end
        cyc(); #1;
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_pulse_m1: got %b want 1", timeout); end
        cyc(); #1;
        checks++; if (pri_req !== 8'h01) begin failures++; $display("FAIL to_penalty_m1: got %h want 01", pri_req); end
        cyc();
        cyc(); #1;
        checks++; if (grant !== 8'h01) begin failures++; $display("FAIL to_return_m0: got %h want 01", grant); end
        req = 8'h00;
        cyc(); #1;
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_drop_no_pulse: got %b want 0", timeout); end
        cyc();
    endtask

    task automatic test_starvation();
        cyc(); req = 8'h01;
        cyc();
        for (int i = 0; i < 4; i++) cyc();
        cyc(); #1;
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL starve_pulse: got %b want 1", timeout); end
        cyc(); #1;
        checks++; if (pri_req !== 8'h00) begin failures++; $display("FAIL starve_masked: got %h want 00", pri_req); end
        checks++; if (pri_en !== 1'b0) begin failures++; $display("FAIL starve_pri_en_low: got %b want 0", pri_en); end
        cyc(); #1;
        checks++; if (pri_req !== 8'h01) begin failures++; $display("FAIL starve_mask_cleared: got %h want 01", pri_req); end
        cyc();
        cyc(); #1;
        checks++; if (grant !== 8'h01) begin failures++; $display("FAIL starve_regrant: got %h want 01", grant); end
        req = 8'h00;
        cyc();
        cyc();
    endtask

    task automatic test_withdraw();
        cyc(); req = 8'h08; #1;
        checks++; if (pri_en !== 1'b1) begin failures++; $display("FAIL wd_pri_en: got %b want 1", pri_en); end
        cyc(); req = 8'h00;
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            checks++; if (grant !== 8'h00) begin failures++; $display("FAIL wd_grant_%0d: got %h want 00", i, grant); end
            checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL wd_busy_%0d: got %b want 0", i, bus_busy); end
        end
    endtask

    task automatic test_reset_mid_grant();
        cyc(); req = 8'h40;
        cyc();
        cyc(); #1;
        checks++; if (grant !== 8'h40) begin failures++; $display("FAIL rmid_grant: got %h want 40", grant); end
        cyc(); rst = 1'b1;
        cyc(); #1;
        checks++; if (grant !== 8'h00) begin failures++; $display("FAIL rmid_grant_cleared: got %h want 00", grant); end
        checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", bus_busy); end
        checks++; if (grant_id !== 3'd0) begin failures++; $display("FAIL rmid_id: got %0d want 0", grant_id); end
        checks++; if (pri_en !== 1'b0) begin failures++; $display("FAIL rmid_pri_en: got %b want 0", pri_en); end
        rst = 1'b0; #1;
        checks++; if (pri_en !== 1'b1) begin failures++; $display("FAIL rmid_rearb_pri_en: got %b want 1", pri_en); end
        cyc(); #1;
        checks++; if (grant !== 8'h00) begin failures++; $display("FAIL rmid_sample: got %h want 00", grant); end
        cyc(); #1;
        checks++; if (grant !== 8'h40) begin failures++; $display("FAIL rmid_fresh_grant: got %h want 40", grant); end
        checks++; if (grant_id !== 3'd6) begin failures++; $display("FAIL rmid_fresh_id: got %0d want 6", grant_id); end
        req = 8'h00;
        cyc();
        cyc();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 8'h00;
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_timeout();
        test_starvation();
        test_withdraw();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
